seg_timer: RTL and testbench
============================

Name: seg_timer

Overview:
Parametrised BCD stopwatch/countdown timer for the UP2 board that drives a row of active-low 7-segment digits. It counts up or down at a programmable tick rate. It takes raw active-low push buttons, which it synchronises and debounces internally, and can load a preset from the slide switches. It replaces the fixed-function display logic in UP2_TOP and feeds DISP1..DISPn directly.

Parameters:
- CLK_HZ, 25175000, MCLK frequency in Hz.
- TICK_HZ, 100, count rate in Hz. CLK_HZ/TICK_HZ must be an integer ≥2.
- DIGITS, 4, number of BCD digits. Range 1..8.
- DEBOUNCE_CYC, 250000, number of consecutive stable cycles a button must hold before it is accepted. Must be ≥1.
- DP_POS, 2, index of the digit whose decimal point is lit. Digit 0 is least significant. A value ≥DIGITS means no decimal point is lit.

Ports:
- MCLK, in, 1, main clock.
- RST_N, in, 1, asynchronous active-low reset.
- BT_START_N, in, 1, raw button, active-low. Each press toggles run/stop.
- BT_CLEAR_N, in, 1, raw button, active-low. Stops the timer and zeroes the count.
- BT_LOAD_N, in, 1, raw button, active-low. Stops the timer and loads PRESET.
- MODE_DOWN, in, 1, 1 selects countdown, 0 selects count-up. Sampled every tick.
- PRESET, in, 4*DIGITS, BCD preset. Digit 0 is in [3:0]. Nibbles >9 are loaded as 9.
- SEG, out, 7*DIGITS, active-low segments {g,f,e,d,c,b,a} per digit. Digit 0 is in [6:0].
- DP, out, DIGITS, active-low decimal points.
- RUNNING, out, 1, 1 while counting.
- DONE, out, 1, one-cycle pulse when a countdown reaches zero.
- WRAP, out, 1, one-cycle pulse when a count-up wraps from all 9s to 0.

Behaviour:
- Reset (RST_N=0, asynchronous) sets:
  - count = 0, RUNNING=0, DONE=0, WRAP=0, prescaler = 0;
  - SEG = 7'b1000000 on every digit;
  - DP[DP_POS] = 0 and all other DP bits = 1;
  - debouncers to the released state.
- Buttons: 2-flop synchroniser, then the btn_debounce stage, then press-edge detect (released→pressed). A single action pulse is produced per press. Holding a button produces no repeats. The action takes effect at most DEBOUNCE_CYC+4 MCLK cycles after the raw falling edge.
- Action priority when pulses coincide in the same cycle: CLEAR > LOAD > START. A lower-priority action in that cycle is discarded.
- CLEAR: count=0, RUNNING=0, prescaler=0.
- LOAD: count=PRESET (nibbles clamped to 9), RUNNING=0, prescaler=0.
- START: toggles RUNNING. In countdown mode, a START with count==0 is ignored and RUNNING stays 0.
- Prescaler:
  - Advances only while RUNNING=1 and holds its value while stopped, so a resumed run continues mid-period.
  - Wraps at CLK_HZ/TICK_HZ-1 and asserts an internal tick for 1 cycle.
- On tick, count-up mode: BCD increment with per-digit carry. All 9s → 0, WRAP=1 for 1 cycle, and counting continues.
- On tick, countdown mode: BCD decrement with per-digit borrow. On the transition to 0: DONE=1 for 1 cycle and RUNNING=0 in the same cycle. The count holds at 0.
- If MODE_DOWN changes mid-run, the new direction applies from the next tick. The count is not altered by the change itself.
- Display:
  - SEG and DP are registered, one cycle after the count.
  - Codes 0..9 are standard. Blank is 7'b1111111.
- An asynchronous reset that occurs mid-press must leave no pending action after release.

Optional Feature:
SEG_TIMER_LZB_EN
- Defined: leading-zero blanking. Digits above the most significant nonzero digit show blank, and their DP bits are forced to 1. Digit 0 and digits ≤DP_POS are never blanked.
- Undefined: all digits always show their value.

Decomposition:
- Package seg_timer_pkg holds:
  - the 7-segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - a BCD digit width constant (4).
- Sub-module btn_debounce (parameter DEBOUNCE_CYC) contains the synchroniser and the stability counter, and outputs a clean level. It is instantiated three times.
- The edge detect, BCD counter and display encoding stay in seg_timer.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100, DIGITS=4, DEBOUNCE_CYC=4.
1. Reset, then one press of START, then wait 10 ticks (100 cycles) → count 0010. SEG digit1 = 7'b1111001, digit0 = 7'b1000000. RUNNING=1.
2. PRESET=16'h0002, MODE_DOWN=1, press LOAD then START, wait 2 ticks → count 0000, DONE high exactly 1 cycle, RUNNING=0. A further START press leaves RUNNING=0.
3. Count-up from a LOAD of 9999, running → next tick gives 0000, WRAP is a 1-cycle pulse, RUNNING stays 1.
4. START and CLEAR pressed in the same cycle while running at 0123 → count 0000, RUNNING=0.
5. START held low for 50 cycles, and separately a 3-cycle glitch → exactly 1 toggle for the hold, none for the glitch. PRESET=16'h00AF loads as 0099.
6. RST_N pulsed low mid-count at 0057, asynchronously → outputs reach their reset values before the next MCLK edge.
7. With SEG_TIMER_LZB_EN defined, DP_POS=2, count 0007 → digit3 is blank; digits 2..0 show 0, 0, 7.

Source files
------------

// File: rtl/seg_timer_pkg.sv
// seg_timer_pkg: shared constants for the BCD stopwatch/countdown timer.
// Holds the active-low 7-segment codes ({g,f,e,d,c,b,a}), the BCD digit width
// and the button index map used by seg_timer.
package seg_timer_pkg;

  localparam int BCD_W = 4;

  // Button slots in the debouncer array.
  localparam int B_START = 0;
  localparam int B_LOAD  = 1;
  localparam int B_CLEAR = 2;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // BCD digit to segment code; non-BCD nibbles show blank.
  function automatic logic [6:0] seg_enc(input logic [BCD_W-1:0] d);
    case (d)
      4'd0:    seg_enc = SEG_0;
      4'd1:    seg_enc = SEG_1;
      4'd2:    seg_enc = SEG_2;
      4'd3:    seg_enc = SEG_3;
      4'd4:    seg_enc = SEG_4;
      4'd5:    seg_enc = SEG_5;
      4'd6:    seg_enc = SEG_6;
      4'd7:    seg_enc = SEG_7;
      4'd8:    seg_enc = SEG_8;
      4'd9:    seg_enc = SEG_9;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stability counter for one raw
// active-low push button. 'pressed' is a clean active-high level that only
// changes after the synchronised input has differed from it for DEBOUNCE_CYC
// consecutive cycles. Reset puts everything in the released state.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync_q;
  logic          pressed_s;
  logic [CW-1:0] cnt_q;

  // Synchroniser, reset to released (high) so a reset mid-press looks idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], btn_n};
  end

  assign pressed_s = ~sync_q[1];

  // Accept a new level only after it has held for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed <= 1'b0;
      cnt_q   <= '0;
    end else if (pressed_s == pressed) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
      pressed <= pressed_s;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg_timer.sv
// seg_timer: BCD stopwatch / countdown timer driving active-low 7-seg digits.
// Buttons are debounced, edge-detected and prioritised CLEAR > LOAD > START.
// Optional macro SEG_TIMER_LZB_EN enables leading-zero blanking.
module seg_timer
  import seg_timer_pkg::*;
#(
  parameter int CLK_HZ       = 25175000,
  parameter int TICK_HZ      = 100,
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int DP_POS       = 2
) (
  input  logic                    MCLK,
  input  logic                    RST_N,
  input  logic                    BT_START_N,
  input  logic                    BT_CLEAR_N,
  input  logic                    BT_LOAD_N,
  input  logic                    MODE_DOWN,
  input  logic [BCD_W*DIGITS-1:0] PRESET,
  output logic [7*DIGITS-1:0]     SEG,
  output logic [DIGITS-1:0]       DP,
  output logic                    RUNNING,
  output logic                    DONE,
  output logic                    WRAP
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [2:0] btn_raw, btn_lvl, btn_lvl_q, btn_act;
  logic       act_clear, act_load, act_start;

  logic [DIGITS-1:0][BCD_W-1:0] cnt_q, cnt_inc, cnt_dec, preset_c;
  logic                         all_nines, cnt_zero, dec_zero;
  logic [PW-1:0]                presc_q;
  logic                         tick, running_q, done_q, wrap_q;

  logic [DIGITS-1:0][6:0] seg_q, seg_d;
  logic [DIGITS-1:0]      dp_q, dp_d, dp_rst, blank;

  assign btn_raw = {BT_CLEAR_N, BT_LOAD_N, BT_START_N};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk    (MCLK),
      .rst_n  (RST_N),
      .btn_n  (btn_raw[b]),
      .pressed(btn_lvl[b])
    );
  end

  // Previous debounced levels for released->pressed detection.
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) btn_lvl_q <= '0;
    else        btn_lvl_q <= btn_lvl;
  end

  assign btn_act   = btn_lvl & ~btn_lvl_q;
  assign act_clear = btn_act[B_CLEAR];
  assign act_load  = btn_act[B_LOAD] & ~btn_act[B_CLEAR];
  assign act_start = btn_act[B_START] & ~btn_act[B_LOAD] & ~btn_act[B_CLEAR];

  // BCD increment/decrement candidates and preset clamping.
  always_comb begin
    logic carry, borrow;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      cnt_inc[i] = cnt_q[i];
      cnt_dec[i] = cnt_q[i];
      if (carry) begin
        if (cnt_q[i] == 4'd9) cnt_inc[i] = 4'd0;
        else begin
          cnt_inc[i] = cnt_q[i] + 1'b1;
          carry      = 1'b0;
        end
      end
      if (borrow) begin
        if (cnt_q[i] == 4'd0) cnt_dec[i] = 4'd9;
        else begin
          cnt_dec[i] = cnt_q[i] - 1'b1;
          borrow     = 1'b0;
        end
      end
      preset_c[i] = (PRESET[BCD_W*i +: BCD_W] > 4'd9) ? 4'd9 : PRESET[BCD_W*i +: BCD_W];
    end
    all_nines = carry;
  end

  assign cnt_zero = (cnt_q == '0);
  assign dec_zero = (cnt_dec == '0);
  assign tick     = running_q && (presc_q == PW'(DIV - 1));

  // Action handling, prescaler and counter; a button action pre-empts a tick.
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q     <= '0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (act_clear) begin
        cnt_q     <= '0;
        presc_q   <= '0;
        running_q <= 1'b0;
      end else if (act_load) begin
        cnt_q     <= preset_c;
        presc_q   <= '0;
        running_q <= 1'b0;
      end else if (act_start) begin
        // Starting a countdown from zero has nothing to do.
        if (running_q || !(MODE_DOWN && cnt_zero)) running_q <= !running_q;
      end else if (running_q) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (MODE_DOWN) begin
            if (cnt_zero) running_q <= 1'b0;
            else begin
              cnt_q <= cnt_dec;
              if (dec_zero) begin
                done_q    <= 1'b1;
                running_q <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_inc;
            if (all_nines) wrap_q <= 1'b1;
          end
        end
      end
    end
  end

  // Display encoding, optional leading-zero blanking and DP placement.
  always_comb begin
    blank = '0;
`ifdef SEG_TIMER_LZB_EN
    begin
      logic keep;
      keep = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
        if (cnt_q[i] != 4'd0 || i == 0 || i <= DP_POS) keep = 1'b1;
        blank[i] = !keep;
      end
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      seg_d[i]  = blank[i] ? SEG_BLANK : seg_enc(cnt_q[i]);
      dp_d[i]   = !((i == DP_POS) && !blank[i]);
      dp_rst[i] = (i != DP_POS);
    end
  end

  // Registered display outputs, one cycle behind the count.
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_q <= {DIGITS{SEG_0}};
      dp_q  <= dp_rst;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign SEG     = seg_q;
  assign DP      = dp_q;
  assign RUNNING = running_q;
  assign DONE    = done_q;
  assign WRAP    = wrap_q;

endmodule

// File: tb/tb_seg_timer.sv
// tb_seg_timer: directed bench for seg_timer at CLK_HZ=1000, TICK_HZ=100
// (10 cycles per tick), DIGITS=4, DEBOUNCE_CYC=4, DP_POS=2.
module tb_seg_timer;

  logic        MCLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        BT_START_N = 1'b1;
  logic        BT_CLEAR_N = 1'b1;
  logic        BT_LOAD_N = 1'b1;
  logic        MODE_DOWN = 1'b0;
  logic [15:0] PRESET = 16'h0000;
  logic [27:0] SEG;
  logic [3:0]  DP;
  logic        RUNNING, DONE, WRAP;

  int checks = 0;
  int errors = 0;
  int n_done, n_wrap, n_tog;

  always #5 MCLK = ~MCLK;

  seg_timer #(
    .CLK_HZ(1000), .TICK_HZ(100), .DIGITS(4), .DEBOUNCE_CYC(4), .DP_POS(2)
  ) dut (
    .MCLK(MCLK), .RST_N(RST_N), .BT_START_N(BT_START_N), .BT_CLEAR_N(BT_CLEAR_N),
    .BT_LOAD_N(BT_LOAD_N), .MODE_DOWN(MODE_DOWN), .PRESET(PRESET),
    .SEG(SEG), .DP(DP), .RUNNING(RUNNING), .DONE(DONE), .WRAP(WRAP)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'b1000000;  4'd1: seg_of = 7'b1111001;
      4'd2: seg_of = 7'b0100100;  4'd3: seg_of = 7'b0110000;
      4'd4: seg_of = 7'b0011001;  4'd5: seg_of = 7'b0010010;
      4'd6: seg_of = 7'b0000010;  4'd7: seg_of = 7'b1111000;
      4'd8: seg_of = 7'b0000000;  4'd9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Expected display for a 4-digit count; with DP_POS=2 only digit 3 can blank.
  function automatic logic [27:0] exp_seg(input logic [15:0] bcd);
    logic [27:0] r;
    for (int i = 0; i < 4; i++) r[7*i +: 7] = seg_of(bcd[4*i +: 4]);
`ifdef SEG_TIMER_LZB_EN
    if (bcd[15:12] == 4'd0) r[27:21] = 7'b1111111;
`endif
    return r;
  endfunction

  // Hold the selected buttons low for 'hold' cycles, observe 'total' cycles.
  task automatic drive(input logic s, input logic l, input logic c, input int hold, input int total);
    logic prev;
    n_done = 0; n_wrap = 0; n_tog = 0;
    @(negedge MCLK);
    BT_START_N = ~s; BT_LOAD_N = ~l; BT_CLEAR_N = ~c;
    prev = RUNNING;
    for (int k = 0; k < total; k++) begin
      @(negedge MCLK);
      if (DONE) n_done++;
      if (WRAP) n_wrap++;
      if (RUNNING !== prev) n_tog++;
      prev = RUNNING;
      if (k == hold - 1) begin
        BT_START_N = 1'b1; BT_LOAD_N = 1'b1; BT_CLEAR_N = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge MCLK);
    checks++; if (SEG !== {4{7'b1000000}}) begin errors++; $display("FAIL reset_seg: got %h want %h", SEG, {4{7'b1000000}}); end
    checks++; if (DP !== 4'b1011) begin errors++; $display("FAIL reset_dp: got %b want 1011", DP); end
    checks++; if ({RUNNING, DONE, WRAP} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {RUNNING, DONE, WRAP}); end
    RST_N = 1'b1;
    repeat (3) @(negedge MCLK);
    checks++; if (SEG !== exp_seg(16'h0000)) begin errors++; $display("FAIL idle_seg: got %h want %h", SEG, exp_seg(16'h0000)); end
  endtask

  task automatic test_count_up();
    int lat;
    MODE_DOWN = 1'b0;
    @(negedge MCLK);
    BT_START_N = 1'b0;
    lat = 0;
    while (RUNNING !== 1'b1 && lat < 12) begin @(negedge MCLK); lat++; end
    checks++; if (lat > 8) begin errors++; $display("FAIL start_latency: got %0d cycles want <= 8", lat); end
    for (int k = 0; k < 102; k++) begin
      @(negedge MCLK);
      if (k == 10) BT_START_N = 1'b1;
    end
    checks++; if (SEG !== exp_seg(16'h0010)) begin errors++; $display("FAIL up_10ticks: got %h want %h", SEG, exp_seg(16'h0010)); end
    checks++; if (RUNNING !== 1'b1) begin errors++; $display("FAIL up_running: got %b want 1", RUNNING); end
  endtask

  task automatic test_countdown();
    PRESET = 16'h0002; MODE_DOWN = 1'b1;
    drive(0, 1, 0, 8, 14);
    checks++; if (SEG !== exp_seg(16'h0002) || RUNNING !== 1'b0) begin errors++; $display("FAIL load_0002: got %h/%b want %h/0", SEG, RUNNING, exp_seg(16'h0002)); end
    drive(1, 0, 0, 8, 60);
    checks++; if (n_done !== 1) begin errors++; $display("FAIL done_pulse: got %0d cycles want 1", n_done); end
    checks++; if (RUNNING !== 1'b0) begin errors++; $display("FAIL done_stops: got %b want 0", RUNNING); end
    checks++; if (SEG !== exp_seg(16'h0000)) begin errors++; $display("FAIL down_zero: got %h want %h", SEG, exp_seg(16'h0000)); end
    drive(1, 0, 0, 8, 20);
    checks++; if (RUNNING !== 1'b0 || n_tog !== 0) begin errors++; $display("FAIL start_at_zero: got run=%b toggles=%0d want 0/0", RUNNING, n_tog); end
  endtask

  task automatic test_wrap();
    PRESET = 16'h9999; MODE_DOWN = 1'b0;
    drive(0, 1, 0, 8, 14);
    drive(1, 0, 0, 10, 25);
    checks++; if (n_wrap !== 1) begin errors++; $display("FAIL wrap_pulse: got %0d cycles want 1", n_wrap); end
    checks++; if (RUNNING !== 1'b1) begin errors++; $display("FAIL wrap_running: got %b want 1", RUNNING); end
    checks++; if (SEG !== exp_seg(16'h0000)) begin errors++; $display("FAIL wrap_zero: got %h want %h", SEG, exp_seg(16'h0000)); end
  endtask

  task automatic test_priority();
    PRESET = 16'h0123;
    drive(0, 1, 0, 8, 14);
    drive(1, 0, 1, 8, 14);
    checks++; if (SEG !== exp_seg(16'h0000) || RUNNING !== 1'b0) begin errors++; $display("FAIL clr_over_start_idle: got %h/%b want %h/0", SEG, RUNNING, exp_seg(16'h0000)); end
    drive(0, 1, 0, 8, 14);
    drive(1, 0, 0, 8, 14);
    checks++; if (RUNNING !== 1'b1) begin errors++; $display("FAIL run_at_0123: got %b want 1", RUNNING); end
    drive(1, 0, 1, 8, 14);
    checks++; if (SEG !== exp_seg(16'h0000) || RUNNING !== 1'b0) begin errors++; $display("FAIL clr_over_start_run: got %h/%b want %h/0", SEG, RUNNING, exp_seg(16'h0000)); end
  endtask

  task automatic test_hold_glitch();
    drive(1, 0, 0, 50, 70);
    checks++; if (n_tog !== 1 || RUNNING !== 1'b1) begin errors++; $display("FAIL hold_once: got toggles=%0d run=%b want 1/1", n_tog, RUNNING); end
    drive(1, 0, 0, 3, 20);
    checks++; if (n_tog !== 0 || RUNNING !== 1'b1) begin errors++; $display("FAIL glitch_ignored: got toggles=%0d run=%b want 0/1", n_tog, RUNNING); end
    PRESET = 16'h00AF;
    drive(0, 1, 0, 8, 14);
    checks++; if (SEG !== exp_seg(16'h0099) || RUNNING !== 1'b0) begin errors++; $display("FAIL clamp_00af: got %h/%b want %h/0", SEG, RUNNING, exp_seg(16'h0099)); end
  endtask

  task automatic test_async_reset();
    PRESET = 16'h0057; MODE_DOWN = 1'b0;
    drive(0, 1, 0, 8, 14);
    drive(1, 0, 0, 8, 14);
    checks++; if (SEG !== exp_seg(16'h0057) || RUNNING !== 1'b1) begin errors++; $display("FAIL run_at_0057: got %h/%b want %h/1", SEG, RUNNING, exp_seg(16'h0057)); end
    @(negedge MCLK);
    BT_START_N = 1'b0;
    repeat (4) @(negedge MCLK);
    #2 RST_N = 1'b0;
    #1;
    checks++; if (SEG !== {4{7'b1000000}} || DP !== 4'b1011) begin errors++; $display("FAIL async_seg_dp: got %h/%b want %h/1011", SEG, DP, {4{7'b1000000}}); end
    checks++; if ({RUNNING, DONE, WRAP} !== 3'b000) begin errors++; $display("FAIL async_flags: got %b want 000", {RUNNING, DONE, WRAP}); end
    repeat (3) @(negedge MCLK);
    BT_START_N = 1'b1;
    repeat (2) @(negedge MCLK);
    RST_N = 1'b1;
    drive(0, 0, 0, 1, 30);
    checks++; if (n_tog !== 0 || RUNNING !== 1'b0) begin errors++; $display("FAIL no_pending_action: got toggles=%0d run=%b want 0/0", n_tog, RUNNING); end
  endtask

  task automatic test_blanking();
    PRESET = 16'h0007;
    drive(0, 1, 0, 8, 14);
    checks++; if (SEG !== exp_seg(16'h0007)) begin errors++; $display("FAIL disp_0007: got %h want %h", SEG, exp_seg(16'h0007)); end
    checks++; if (DP !== 4'b1011) begin errors++; $display("FAIL dp_0007: got %b want 1011", DP); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_countdown();
    test_wrap();
    test_priority();
    test_hold_glitch();
    test_async_reset();
    test_blanking();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
